// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
package rst_seq_pkg;

  localparam int DEF_NUM_DOM  = 4;
  localparam int DEF_MIN_HOLD = 8;
  localparam int DEF_TIMEOUT  = 64;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_DONE     = 2'd2,
    ST_ERROR    = 2'd3
  } rst_seq_state_e;

  // The shared timer is loaded with (cycles - 1), so it must hold max(hold, timeout) - 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter with terminal-count flag; serves both the hold
// interval and the per-domain ready timeout.
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register; the owner loads it whenever it enters a timed phase.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets, then releases domains one by
// one as each previously released domain reports ready, with a timeout.
// Optional macro RST_SEQ_ASSERT_EN compiles embedded sequencing assertions.
//
// state       | meaning
// ST_HOLD     | all resets asserted, hold timer running
// ST_WAIT_RDY | domains 0..idx released, waiting for dom_ready[idx]
// ST_DONE     | all domains released and ready, ready inputs ignored
// ST_ERROR    | ready timeout, all resets re-asserted, err_dom latched
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM  = DEF_NUM_DOM,
  parameter int MIN_HOLD = DEF_MIN_HOLD,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  input  logic [NUM_DOM-1:0] dom_ready,
  output logic [NUM_DOM-1:0] dom_rst,
  output logic               seq_done,
  output logic               timeout_err,
  output logic [3:0]         err_dom
);

  localparam int               CNT_W    = cnt_width(MIN_HOLD, TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LAST_IDX = 4'(NUM_DOM - 1);

  rst_seq_state_e     state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         err_dom_q, err_dom_d;
  logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
  logic               tmr_load, tmr_en, tmr_tc;
  logic [CNT_W-1:0]   tmr_val;
  logic [15:0]        rdy_ext;

  // Widened so a 4-bit index never selects outside the vector.
  assign rdy_ext = 16'(dom_ready);

  rst_seq_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  // Next-state logic; a restart request beats any same-cycle ready or timeout.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_dom_d = err_dom_q;
    tmr_load  = 1'b0;
    tmr_val   = HOLD_LD;
    tmr_en    = 1'b0;
    if (rst || sw_rst_req) begin
      state_d   = ST_HOLD;
      idx_d     = '0;
      err_dom_d = '0;
      tmr_load  = 1'b1;
      tmr_val   = HOLD_LD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (tmr_tc) begin
            state_d  = ST_WAIT_RDY;
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = TMO_LD;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_WAIT_RDY: begin
          if (rdy_ext[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d    = idx_q + 4'd1;
              tmr_load = 1'b1;
              tmr_val  = TMO_LD;
            end
          end else if (tmr_tc) begin
            state_d   = ST_ERROR;
            err_dom_d = idx_q;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_HOLD;
      endcase
    end
  end

  // Reset vector follows the next state so dom_rst comes straight from a flop.
  always_comb begin
    dom_rst_d = '1;
    case (state_d)
      ST_DONE: dom_rst_d = '0;
      ST_WAIT_RDY: begin
        for (int i = 0; i < NUM_DOM; i++) begin
          dom_rst_d[i] = (4'(i) > idx_d);
        end
      end
      default: dom_rst_d = '1;
    endcase
  end

  // State, index and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      idx_q     <= '0;
      err_dom_q <= '0;
      dom_rst_q <= '1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_dom_q <= err_dom_d;
      dom_rst_q <= dom_rst_d;
    end
  end

  assign dom_rst     = dom_rst_q;
  assign seq_done    = (state_q == ST_DONE);
  assign timeout_err = (state_q == ST_ERROR);
  assign err_dom     = err_dom_q;

`ifdef RST_SEQ_ASSERT_EN
  for (genvar i = 0; i < NUM_DOM - 1; i++) begin : g_order
    a_order: assert property (@(posedge clk) disable iff (rst)
      $fell(dom_rst[i]) |-> (dom_rst[i+1] until dom_ready[i]))
      else $error("dom_rst[%0d] released before dom_ready[%0d]", i + 1, i);
  end

  a_done_all_released: assert property (@(posedge clk) disable iff (rst)
    $rose(seq_done) |-> (dom_rst == '0))
    else $error("seq_done rose with a domain still in reset");

  a_error_all_reset: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_ERROR) |-> (dom_rst == '1))
    else $error("error state with a domain out of reset");
`else
`endif

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOM, default 4, number of downstream reset domains (1..16).
REQ-002 SHALL have parameter MIN_HOLD, default 8, cycles all domain resets stay asserted before the first release (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum wait cycles for a released domain's ready (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port rst  input  1  one clock; reset is synchronous and active-high.
REQ-006 SHALL have port sw_rst_req  input  1  software pulse restarting the sequence.
REQ-007 SHALL have port dom_ready  input  NUM_DOM  per-domain ready, bit i from domain i.
REQ-008 SHALL have port dom_rst  output  NUM_DOM  per-domain reset, active-high, registered.
REQ-009 SHALL have port seq_done  output  1  all domains released and ready.
REQ-010 SHALL have port timeout_err  output  1  sticky timeout flag.
REQ-011 SHALL have port err_dom  output  4  index of the domain that timed out.

Function
REQ-012 SHALL implement FSM states HOLD, WAIT_RDY, DONE, ERROR with a domain index idx.
REQ-013 HOLD: all dom_rst=1; hold counter counts MIN_HOLD cycles, then dom_rst[0] deasserts on the next edge, idx=0, state becomes WAIT_RDY.
REQ-014 WAIT_RDY: dom_ready[idx]=1 sampled at edge t -> dom_rst[idx+1] deasserts at edge t+1, idx increments, wait counter clears.
REQ-015 WAIT_RDY with idx=NUM_DOM-1 and dom_ready[idx]=1 -> DONE; seq_done=1 from the next edge.
REQ-016 Invariant: dom_rst[i+1] SHALL stay high until dom_ready[i] has been sampled high in WAIT_RDY with idx=i.
REQ-017 Wait counter increments each WAIT_RDY cycle without ready; ready on the TIMEOUT-th wait cycle is accepted; absence -> ERROR next edge.
REQ-018 ERROR: all dom_rst=1, timeout_err=1, err_dom=idx latched, seq_done=0; held until sw_rst_req or rst.
REQ-019 DONE: dom_rst all 0; dom_ready changes SHALL be ignored; state held until sw_rst_req or rst.
REQ-020 sw_rst_req=1 in any state -> HOLD next edge, all dom_rst=1, counters and idx cleared, seq_done=0, timeout_err=0.
REQ-021 sw_rst_req SHALL take priority over a simultaneous ready or timeout.
REQ-022 dom_ready bits of unreleased domains and all ready bits during HOLD SHALL be ignored.
REQ-023 NUM_DOM=1: DONE directly after dom_ready[0]; err_dom=0 always.

Reset
REQ-024 rst=1 SHALL force HOLD next edge: dom_rst all 1, seq_done=0, timeout_err=0, err_dom=0, idx=0, counters 0.
REQ-025 rst mid-sequence (any state) SHALL behave identically to REQ-024; rst dominates sw_rst_req.

Configuration
REQ-026 Macro RST_SEQ_ASSERT_EN defined: embedded concurrent assertions SHALL check, for each i, "$fell(dom_rst[i]) |-> dom_rst[i+1] until dom_ready[i]", "$rose(seq_done) |-> dom_rst==0", and "ERROR |-> dom_rst all ones", each with an $error action message.
REQ-027 Macro undefined: no assertions compiled; RTL behaviour identical.

Structure
REQ-028 Package rst_seq_pkg SHALL hold the state enum typedef and default constants for NUM_DOM, MIN_HOLD, TIMEOUT.
REQ-029 Sub-module rst_seq_timer SHALL provide a loadable cycle counter with terminal-count flag, reused for hold and timeout.

Verification (NUM_DOM=4, MIN_HOLD=8, TIMEOUT=16)
REQ-030 Nominal: rst released, each dom_ready[i] raised 3 cycles after dom_rst[i] falls -> dom_rst bits fall in order 0..3, seq_done=1, no error.
REQ-031 Timeout: dom_ready[2] held 0 -> 16 wait cycles later ERROR, timeout_err=1, err_dom=2, dom_rst=4'b1111.
REQ-032 Boundary: dom_ready[1] raised exactly on wait cycle 16 -> accepted, no error; on cycle 17 -> error, err_dom=1.
REQ-033 Restart: sw_rst_req pulsed in WAIT_RDY idx=1 coincident with dom_ready[1] -> HOLD, dom_rst=4'b1111, sequence restarts after 8 cycles.
REQ-034 Early ready: all dom_ready=1 from time 0 -> dom_rst[0] falls after 8 hold cycles, then one domain released per cycle, seq_done 4 cycles later.
REQ-035 rst asserted while in DONE and while in ERROR -> all outputs at REQ-024 values next edge.
